// File: rtl/block_token_emitter.sv
// block_token_emitter: turns begin/end/filler/space token commands into a
// registered ASCII character stream, one char per clk, each token followed by
// a single separator. Tracks BEGIN/END nesting depth and a sticky error flag.
// Optional feature macro: MIXED_CASE_EN (adds cmd_upper per-letter uppercase mask).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no token in flight, char_out holds SPACE_CHAR, char_valid=0
// ST_EMIT  | emitting letters of the latched token, one per cycle
// ST_SPACE | trailing separator on char_out for one cycle, may accept

module block_token_emitter #(
   parameter int          DEPTH_W    = 8,
   parameter logic [7:0]  SPACE_CHAR = 8'h20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [2:0]         cmd_len,
`ifdef MIXED_CASE_EN
   input  logic [4:0]         cmd_upper,
`endif
   output logic [7:0]         char_out,
   output logic               char_valid,
   output logic               busy,
   output logic [DEPTH_W-1:0] depth,
   output logic               err,
   output logic               balanced
);

   localparam logic [1:0] T_BEGIN  = 2'b00;
   localparam logic [1:0] T_END    = 2'b01;
   localparam logic [1:0] T_FILLER = 2'b10;
   localparam logic [1:0] T_SPACE  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EMIT  = 2'b01,
      ST_SPACE = 2'b10
   } state_t;

   state_t             state, state_nxt;
   logic [2:0]         idx, idx_nxt;
   logic [1:0]         lat_type, type_nxt;
   logic [2:0]         lat_len, len_nxt;
   logic [4:0]         lat_upper, upper_nxt;
   logic [7:0]         char_nxt;
   logic               valid_nxt;
   logic [DEPTH_W-1:0] depth_nxt;
   logic               err_nxt;
   logic [4:0]         upper_in;
   logic [2:0]         last_idx;
   logic               accept;

`ifdef MIXED_CASE_EN
   assign upper_in = cmd_upper;
`else
   assign upper_in = 5'b00000;
`endif

   // Letter i of a token; mask bits past bit 4 read as zero so long fillers stay lowercase.
   function automatic logic [7:0] letter_of(input logic [1:0] t, input logic [2:0] i,
                                            input logic [4:0] up);
      logic [7:0] ch;
      logic [7:0] upx;
      upx = {3'b000, up};
      ch  = SPACE_CHAR;
      case (t)
         T_BEGIN: begin
            case (i)
               3'd0:    ch = 8'h62;
               3'd1:    ch = 8'h65;
               3'd2:    ch = 8'h67;
               3'd3:    ch = 8'h69;
               3'd4:    ch = 8'h6e;
               default: ch = SPACE_CHAR;
            endcase
         end
         T_END: begin
            case (i)
               3'd0:    ch = 8'h65;
               3'd1:    ch = 8'h6e;
               3'd2:    ch = 8'h64;
               default: ch = SPACE_CHAR;
            endcase
         end
         T_FILLER: ch = 8'h61;
         default:  ch = SPACE_CHAR;
      endcase
      if (upx[i] && (ch != SPACE_CHAR)) ch = ch - 8'h20;
      return ch;
   endfunction

   assign cmd_ready = (state == ST_IDLE) || (state == ST_SPACE);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != ST_IDLE);
   assign balanced  = (depth == '0) && !err;

   // Index of the final letter of the latched token.
   always_comb begin
      last_idx = 3'd0;
      case (lat_type)
         T_BEGIN:  last_idx = 3'd4;
         T_END:    last_idx = 3'd2;
         T_FILLER: last_idx = lat_len;
         default:  last_idx = 3'd0;
      endcase
   end

   // Next-state, next-char and depth/err update; an accept overrides the state's own path.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      type_nxt  = lat_type;
      len_nxt   = lat_len;
      upper_nxt = lat_upper;
      char_nxt  = char_out;
      valid_nxt = char_valid;
      depth_nxt = depth;
      err_nxt   = err;
      case (state)
         ST_IDLE: begin
            char_nxt  = SPACE_CHAR;
            valid_nxt = 1'b0;
         end
         ST_EMIT: begin
            valid_nxt = 1'b1;
            if (idx == last_idx) begin
               state_nxt = ST_SPACE;
               char_nxt  = SPACE_CHAR;
            end else begin
               idx_nxt  = idx + 3'd1;
               char_nxt = letter_of(lat_type, idx + 3'd1, lat_upper);
            end
         end
         ST_SPACE: begin
            state_nxt = ST_IDLE;
            char_nxt  = SPACE_CHAR;
            valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = ST_IDLE;
            char_nxt  = SPACE_CHAR;
            valid_nxt = 1'b0;
         end
      endcase
      if (accept) begin
         type_nxt  = cmd_type;
         len_nxt   = cmd_len;
         upper_nxt = upper_in;
         idx_nxt   = 3'd0;
         valid_nxt = 1'b1;
         if (cmd_type == T_SPACE) begin
            state_nxt = ST_SPACE;
            char_nxt  = SPACE_CHAR;
         end else begin
            state_nxt = ST_EMIT;
            char_nxt  = letter_of(cmd_type, 3'd0, upper_in);
         end
         if (cmd_type == T_BEGIN) begin
            if (depth == '1) err_nxt = 1'b1;
            else             depth_nxt = depth + DEPTH_W'(1);
         end else if (cmd_type == T_END) begin
            if (depth == '0) err_nxt = 1'b1;
            else             depth_nxt = depth - DEPTH_W'(1);
         end
      end
   end

   // State, output char and tracking registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         lat_type   <= T_BEGIN;
         lat_len    <= 3'd0;
         lat_upper  <= 5'b00000;
         char_out   <= SPACE_CHAR;
         char_valid <= 1'b0;
         depth      <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         lat_type   <= type_nxt;
         lat_len    <= len_nxt;
         lat_upper  <= upper_nxt;
         char_out   <= char_nxt;
         char_valid <= valid_nxt;
         depth      <= depth_nxt;
         err        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_block_token_emitter.sv
// Directed bench for block_token_emitter. Characters are sampled on the falling
// edge; '_' in a captured string stands for a cycle with char_valid low.
module tb_block_token_emitter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_type;
   logic [2:0] cmd_len;
   logic [4:0] cmd_upper;
   logic [7:0] char_out;
   logic       char_valid;
   logic       busy;
   logic [7:0] depth;
   logic       err;
   logic       balanced;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   block_token_emitter #(.DEPTH_W(8), .SPACE_CHAR(8'h20)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_type   (cmd_type),
      .cmd_len    (cmd_len),
`ifdef MIXED_CASE_EN
      .cmd_upper  (cmd_upper),
`endif
      .char_out   (char_out),
      .char_valid (char_valid),
      .busy       (busy),
      .depth      (depth),
      .err        (err),
      .balanced   (balanced)
   );

   task automatic do_reset();
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_type  = 2'b00;
      cmd_len   = 3'd0;
      cmd_upper = 5'b00000;
      #12;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [2:0] l, input logic [4:0] u);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_len   = l;
      cmd_upper = u;
   endtask

   // Records n falling-edge samples; drops cmd_valid and scrambles the command
   // fields the cycle after an accept so latching is exercised.
   task automatic capture(input int n, output string s);
      logic pend;
      pend = 1'b0;
      s    = "";
      for (int i = 0; i < n; i++) begin
         if (pend) begin
            cmd_valid = 1'b0;
            cmd_type  = 2'b00;
            cmd_len   = 3'd7;
            cmd_upper = 5'h1f;
         end
         s    = $sformatf("%s%c", s, char_valid ? char_out : 8'h5f);
         pend = cmd_valid && cmd_ready;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      string s;
      do_reset();
      checks++;
      if (char_out !== 8'h20 || char_valid !== 1'b0 || depth !== 8'd0 || err !== 1'b0 ||
          balanced !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_init: char=%h valid=%b depth=%0d err=%b bal=%b rdy=%b busy=%b want 20 0 0 0 1 1 0",
                  char_out, char_valid, depth, err, balanced, cmd_ready, busy);
      end
      issue(2'b00, 3'd0, 5'b0);
      capture(3, s);
      checks++;
      if (depth !== 8'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre_state: depth=%0d busy=%b want 1 1", depth, busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (char_out !== 8'h20 || char_valid !== 1'b0 || depth !== 8'd0 || err !== 1'b0 ||
          balanced !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_midrun: char=%h valid=%b depth=%0d err=%b bal=%b rdy=%b busy=%b want 20 0 0 0 1 1 0",
                  char_out, char_valid, depth, err, balanced, cmd_ready, busy);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_begin();
      string s;
      do_reset();
      issue(2'b00, 3'd0, 5'b0);
      capture(8, s);
      checks++;
      if (s != "_begin _") begin
         failures++;
         $display("FAIL begin_chars: got \"%s\" want \"_begin _\"", s);
      end
      checks++;
      if (depth !== 8'd1 || balanced !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL begin_depth: depth=%0d bal=%b err=%b want 1 0 0", depth, balanced, err);
      end
   endtask

   task automatic test_back_to_back();
      string s;
      do_reset();
      issue(2'b00, 3'd0, 5'b0);
      @(negedge clk);
      cmd_type = 2'b01;
      checks++;
      if (depth !== 8'd1) begin
         failures++;
         $display("FAIL b2b_depth_after_begin: depth=%0d want 1", depth);
      end
      capture(12, s);
      checks++;
      if (s != "begin end __") begin
         failures++;
         $display("FAIL b2b_chars: got \"%s\" want \"begin end __\"", s);
      end
      checks++;
      if (depth !== 8'd0 || balanced !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_depth: depth=%0d bal=%b err=%b want 0 1 0", depth, balanced, err);
      end
   endtask

   task automatic test_end_underflow();
      string s;
      do_reset();
      issue(2'b01, 3'd0, 5'b0);
      capture(6, s);
      checks++;
      if (s != "_end _") begin
         failures++;
         $display("FAIL underflow_chars: got \"%s\" want \"_end _\"", s);
      end
      checks++;
      if (depth !== 8'd0 || err !== 1'b1 || balanced !== 1'b0) begin
         failures++;
         $display("FAIL underflow_flags: depth=%0d err=%b bal=%b want 0 1 0", depth, err, balanced);
      end
      issue(2'b00, 3'd0, 5'b0);
      capture(8, s);
      issue(2'b01, 3'd0, 5'b0);
      capture(6, s);
      checks++;
      if (depth !== 8'd0 || err !== 1'b1 || balanced !== 1'b0) begin
         failures++;
         $display("FAIL underflow_sticky: depth=%0d err=%b bal=%b want 0 1 0", depth, err, balanced);
      end
   endtask

   task automatic test_filler_space();
      string s;
      do_reset();
      issue(2'b10, 3'd2, 5'b0);
      @(negedge clk);
      cmd_type = 2'b11;
      capture(7, s);
      checks++;
      if (s != "aaa  __") begin
         failures++;
         $display("FAIL filler_space_chars: got \"%s\" want \"aaa  __\"", s);
      end
      checks++;
      if (depth !== 8'd0 || busy !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL filler_space_state: depth=%0d busy=%b err=%b rdy=%b want 0 0 0 1",
                  depth, busy, err, cmd_ready);
      end
   endtask

   task automatic test_filler_max();
      string s;
      do_reset();
      issue(2'b10, 3'd7, 5'b0);
      capture(11, s);
      checks++;
      if (s != "_aaaaaaaa _") begin
         failures++;
         $display("FAIL filler_max_chars: got \"%s\" want \"_aaaaaaaa _\"", s);
      end
   endtask

   task automatic test_mixed_case();
      string s;
      string want;
`ifdef MIXED_CASE_EN
      want = "_bEGiN _";
`else
      want = "_begin _";
`endif
      do_reset();
      issue(2'b00, 3'd0, 5'b10110);
      capture(8, s);
      checks++;
      if (s != want) begin
         failures++;
         $display("FAIL mixed_case_chars: got \"%s\" want \"%s\"", s, want);
      end
   endtask

   task automatic test_depth_max();
      string s;
      do_reset();
      for (int i = 0; i < 255; i++) begin
         issue(2'b00, 3'd0, 5'b0);
         capture(7, s);
      end
      checks++;
      if (depth !== 8'd255 || err !== 1'b0 || balanced !== 1'b0) begin
         failures++;
         $display("FAIL depth_full: depth=%0d err=%b bal=%b want 255 0 0", depth, err, balanced);
      end
      issue(2'b00, 3'd0, 5'b0);
      capture(7, s);
      checks++;
      if (depth !== 8'd255 || err !== 1'b1 || s != "_begin ") begin
         failures++;
         $display("FAIL depth_overflow: depth=%0d err=%b chars=\"%s\" want 255 1 \"_begin \"",
                  depth, err, s);
      end
      issue(2'b01, 3'd0, 5'b0);
      capture(5, s);
      checks++;
      if (depth !== 8'd254 || err !== 1'b1) begin
         failures++;
         $display("FAIL depth_after_end: depth=%0d err=%b want 254 1", depth, err);
      end
   endtask

   initial begin
      test_reset();
      test_begin();
      test_back_to_back();
      test_end_underflow();
      test_filler_space();
      test_filler_max();
      test_mixed_case();
      test_depth_max();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
